// File: rtl/rf_fp_multiport.sv
// Multi-port FP physical register file with a per-entry ready scoreboard.
// Reads are registered (1-cycle latency) and write-first: a read that hits an
// address being written on the same edge returns the new data and the
// post-update ready bit. Among several write ports hitting one address the
// highest-index port wins; allocation (ready clear) beats writeback (ready set).
// No handshake: every port is accepted every cycle.
module rf_fp_multiport #(
    parameter int SIZE      = 64,
    parameter int WIDTH     = 32,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 4,
    parameter int NUM_ALLOC = 2,
    localparam int ADDR_W   = $clog2(SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_WR-1:0]           wen,
    input  logic [NUM_WR*ADDR_W-1:0]    waddr,
    input  logic [NUM_WR*WIDTH-1:0]     wdata,
    input  logic [NUM_ALLOC-1:0]        aen,
    input  logic [NUM_ALLOC*ADDR_W-1:0] aaddr,
    input  logic [NUM_RD-1:0]           ren,
    input  logic [NUM_RD*ADDR_W-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0]     rdata,
    output logic [NUM_RD-1:0]           rready
);

    // Data array: not reset, contents undefined until written.
    logic [WIDTH-1:0]        mem_q [SIZE];
    logic [SIZE-1:0]         ready_q;
    logic [SIZE-1:0]         ready_d;
    logic [NUM_RD*WIDTH-1:0] rdata_q;
    logic [NUM_RD*WIDTH-1:0] rdata_d;
    logic [NUM_RD-1:0]       rready_q;
    logic [NUM_RD-1:0]       rready_d;

    // Unpacked views of the flattened address / data buses.
    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [WIDTH-1:0]  wr_data [NUM_WR];
    logic [ADDR_W-1:0] al_addr [NUM_ALLOC];
    logic [ADDR_W-1:0] rd_addr [NUM_RD];

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wr_addr[k] = waddr[k*ADDR_W +: ADDR_W];
        assign wr_data[k] = wdata[k*WIDTH +: WIDTH];
    end
    for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_al
        assign al_addr[a] = aaddr[a*ADDR_W +: ADDR_W];
    end
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        assign rd_addr[j] = raddr[j*ADDR_W +: ADDR_W];
    end

    // Next scoreboard: writeback sets, then allocation clears (clear wins).
    always_comb begin
        ready_d = ready_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wen[k]) ready_d[wr_addr[k]] = 1'b1;
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (aen[a]) ready_d[al_addr[a]] = 1'b0;
        end
    end

    // Next read outputs: array value, overridden by same-edge writes in
    // ascending port order so the highest-index hit wins; hold when disabled.
    always_comb begin
        rdata_d  = rdata_q;
        rready_d = rready_q;
        for (int j = 0; j < NUM_RD; j++) begin
            if (ren[j]) begin
                rdata_d[j*WIDTH +: WIDTH] = mem_q[rd_addr[j]];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wen[k] && (wr_addr[k] == rd_addr[j])) begin
                        rdata_d[j*WIDTH +: WIDTH] = wr_data[k];
                    end
                end
                rready_d[j] = ready_d[rd_addr[j]];
            end
        end
    end

    // State update; edges are ignored while reset is held, so pending writes
    // on the asserting edge are dropped. The data array itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= '1;
            rdata_q  <= '0;
            rready_q <= '0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rready_q <= rready_d;
            for (int k = 0; k < NUM_WR; k++) begin
                if (wen[k]) mem_q[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    assign rdata  = rdata_q;
    assign rready = rready_q;

endmodule

// File: doc/rf_fp_multiport.md
Name: rf_fp_multiport

Overview:
- Parametrised successor to the FP physical register file: NUM_WR write ports, NUM_RD read ports, configurable SIZE/WIDTH.
- Adds registered reads with a 1-cycle latency, same-cycle write-to-read bypass, and deterministic write-conflict priority.
- Adds a per-entry ready scoreboard, cleared by rename-time allocation and set by writeback.
- Sits between the FP rename/issue stage (alloc, operand reads) and the FP writeback ports.

Parameters:
SIZE, 64, number of physical entries (power of two, >= 4)
WIDTH, 32, data bits per entry
NUM_WR, 2, write ports (1..4)
NUM_RD, 4, read ports (1..8)
NUM_ALLOC, 2, allocation (ready-clear) ports (1..4)
ADDR_W, $clog2(SIZE), derived; not to be overridden

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wen  in  NUM_WR  per-port write enable
waddr  in  NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
wdata  in  NUM_WR*WIDTH  write data, port k at [k*WIDTH +: WIDTH]
aen  in  NUM_ALLOC  per-port allocation enable
aaddr  in  NUM_ALLOC*ADDR_W  entries being allocated (ready cleared)
ren  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses
rdata  out  NUM_RD*WIDTH  registered read data
rready  out  NUM_RD  registered ready bit of the entry read

Behaviour:
- Reset (rst_n low, async): rdata = 0 and rready = 0 on all ports; the scoreboard is set all-ready (1). Data array contents are not reset. Rising-edge logic is ignored while rst_n is low.
- Write: on each edge, for each k with wen[k], mem[waddr[k]] <= wdata[k].
  - Same address on several enabled ports: the highest-index port wins.
- Scoreboard: for each enabled write port, ready[waddr] <= 1. For each enabled alloc port, ready[aaddr] <= 0.
  - If an entry is both allocated and written in the same cycle, clear wins (ready = 0; data is still written).
  - Duplicate alloc addresses are harmless.
- Read: if ren[j] is high at edge t, then at t+1 rdata[j] and rready[j] reflect the entry at raddr[j].
  - If ren[j] is low, both outputs hold their previous value.
- Bypass (write-first): if an enabled write port targets raddr[j] in the same cycle, rdata[j] takes that port's wdata. The same highest-index priority applies. rready[j] takes the post-update scoreboard value, i.e. the write/alloc result computed for that edge.
- Read ports are independent. Any number may hit the same address, and every hit receives identical data.
- Address width: waddr, raddr and aaddr are exactly ADDR_W bits wide, so no out-of-range access is possible. SIZE must be a power of two.
- No handshake stall: every port is accepted every cycle. Throughput is NUM_WR writes and NUM_RD reads per cycle.
- Reset mid-operation: outputs clear immediately. Pending writes on the asserting edge are discarded. The first read after deassertion returns array contents, which are undefined unless written since power-up.

Test Plan:
1. Reset then read: rst_n=0 for 2 cycles, release; ren[0]=1, raddr0=5 → next cycle rready[0]=1. During reset, rdata=0 and rready=0 on all ports.
2. Write then read: port0 writes 0x3F800000 to entry 10 at cycle t; at t+1 read entry 10 on ports 0..3 → all rdata=0x3F800000, rready=1.
3. Bypass plus write conflict: in the same cycle, port0 writes 0x11111111 and port1 writes 0x22222222 to entry 7, and port2 reads entry 7 → rdata2=0x22222222 next cycle; a later read of 7 also returns 0x22222222.
4. Scoreboard:
   - alloc entry 20 → a read the next cycle gives rready=0.
   - write 0x40490FDB to 20 → the following read gives rready=1 and that data.
   - alloc and write entry 20 in the same cycle → rready=0 and data=new value.
5. Read hold: read entry 3 (value 0xA5A5A5A5), then ren=0 for 3 cycles while entry 3 is rewritten to 0 → rdata stays 0xA5A5A5A5 until ren is reasserted.
6. Async reset mid-operation: assert rst_n low between edges during active writes → rdata/rready go 0 without waiting for a clock edge. After release, every entry reads rready=1.
